mem_dbus_stage: RTL and testbench
=================================

// Module: mem_dbus_stage
// PURPOSE
//  Memory-access stage of the OpenMIPS pipeline, between ex_mem and mem_wb. Passes
//  non-memory results through unchanged. Runs load/store instructions over a
//  single-master data bus with a req/ack handshake, using a small FSM.
//  Raises stallreq to ctrl until the access completes, then presents the
//  sign/zero-extended load result on the mem_* outputs that mem_wb consumes.
// PARAMETERS
//  BIG_ENDIAN  1  1: byte 0 is bits [31:24] (MIPS big-endian); 0: little-endian lane map
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   asynchronous, active-low reset
//  stall        in   6   ctrl pipeline stall vector; only stall[4] is used here
//  ex_wd        in   5   dest reg address from ex_mem
//  ex_wreg      in   1   dest reg write enable from ex_mem
//  ex_wdata     in   32  ALU result / store data from ex_mem
//  ex_hi,ex_lo  in   32  HI/LO write values from ex_mem
//  ex_whilo     in   1   HI/LO write enable from ex_mem
//  ex_aluop     in   8   operation code (`EXE_*_OP)
//  ex_mem_addr  in   32  effective byte address for loads/stores
//  ex_reg2      in   32  store source operand
//  mem_wd,mem_wreg,mem_wdata,mem_hi,mem_lo,mem_whilo  out  5/1/32/32/32/1  to mem_wb
//  mem_misalign out  1   misaligned access detected (1 for that instruction)
//  stallreq     out  1   pipeline stall request to ctrl
//  dbus_req     out  1   bus request, held until ack
//  dbus_we      out  1   1 = write
//  dbus_addr    out  32  word-aligned address {addr[31:2],2'b00}
//  dbus_sel     out  4   byte lane enables
//  dbus_wdata   out  32  lane-replicated store data
//  dbus_rdata   in   32  read data, valid with ack
//  dbus_ack     in   1   one-cycle completion strobe
// BEHAVIOUR
//  - Reset (rst=0, async): FSM=IDLE; every output 0 (mem_wd=`NOPRegAddr, mem_wreg and
//    mem_whilo disabled, dbus_req=0, stallreq=0). Aborts any in-flight access at once.
//  - Mem op = LB,LBU,LH,LHU,LW,SB,SH,SW. Every other op passes through combinationally
//    with zero latency; stallreq=0.
//  - Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
//    No bus cycle; mem_misalign=1; mem_wreg=0; stallreq=0.
//  - FSM IDLE: an aligned mem op asserts stallreq combinationally.
//    At that clock edge it registers dbus_req=1 plus addr/we/sel/wdata, then goes to BUSY.
//  - BUSY: stallreq=1; bus outputs held stable. On dbus_ack=1 it captures
//    dbus_rdata into rd_buf, registers dbus_req=0 and goes to DONE.
//  - DONE: stallreq=0. Loads drive mem_wreg=ex_wreg and mem_wdata=ext(rd_buf).
//    Stores drive mem_wreg=0. Moves to IDLE on the edge where stall[4]==`NoStop;
//    otherwise stays in DONE and holds rd_buf.
//  - In IDLE/BUSY with a mem op present, mem_wreg=0 and mem_whilo=0. This is the
//    bubble that mem_wb inserts.
//  - dbus_ack in IDLE or DONE is ignored. Minimum load: 3 cycles in stage.
//    stallreq is high for 2 of them when ack arrives in the first BUSY cycle.
//  - Lane map (BIG_ENDIAN=1), addr[1:0]=0..3 -> byte sel 1000,0100,0010,0001.
//    Halfword offset 0/2 -> sel 1100/0011.
//    SB wdata={4{b}}; SH wdata={2{h}}; SW wdata=reg2, sel 1111.
//  - Extension: LB/LH sign-extend from bit 7/15 of the selected lane;
//    LBU/LHU zero-extend. LW uses rd_buf unchanged.
//  - HI/LO outputs always pass through from ex_*; mem_whilo=0 for mem ops.
// STRUCTURE
//  - Op codes, `Stop/`NoStop, `ZeroWord, `NOPRegAddr and state encodings
//    (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) live in defines.v.
//  - One sub-module, dbus_if: FSM plus registered bus outputs plus rd_buf.
//  - Top level holds lane select, extension, misalign detection and the pass-through mux.
// TESTING
//  - ADDU, ex_wdata=0x00000005, wd=3 -> same cycle mem_wdata=5, mem_wreg=1, stallreq=0, no dbus_req.
//  - LW addr 0x100, ack on 2nd BUSY cycle, rdata 0x12345678
//    -> dbus_addr 0x100, sel 1111; stallreq high 3 cycles; DONE: mem_wdata 0x12345678.
//  - LB/LBU addr 0x101, rdata 0x12F45678 -> sel 0100; LB=0xFFFFFFF4, LBU=0x000000F4.
//  - SH addr 0x102, reg2 0x0000ABCD -> we=1, sel 0011, wdata 0xABCDABCD, mem_wreg=0 in DONE.
//  - LW addr 0x102 -> mem_misalign=1, dbus_req never 1, stallreq=0, mem_wreg=0.
//  - Reset pulsed low in BUSY -> dbus_req and stallreq drop same cycle; next LW runs cleanly.
//  - Hold stall[4]=Stop 2 extra cycles in DONE
//    -> no second bus request, result held, exits to IDLE on release.

Source files
------------

// File: rtl/mem_dbus_stage_pkg.sv
// mem_dbus_stage_pkg: op codes, pipeline constants and data-bus FSM states for the memory stage
package mem_dbus_stage_pkg;
  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_LB_OP   = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP  = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP   = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP  = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP   = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP   = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP   = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP   = 8'b1110_1011;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } dbus_state_e;
  function automatic logic is_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction
  function automatic logic is_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction
  function automatic logic is_byte(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP};
  endfunction
  function automatic logic is_half(input logic [7:0] op);
    return op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
  endfunction
  function automatic logic is_word(input logic [7:0] op);
    return op inside {EXE_LW_OP, EXE_SW_OP};
  endfunction
endpackage

// File: rtl/mem_dbus_stage_dbus_if.sv
// dbus_if: req/ack data-bus FSM with registered bus outputs and the read buffer
module dbus_if
  import mem_dbus_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        release_stage,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output dbus_state_e state,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  output logic [31:0] rd_buf
);
  dbus_state_e state_q, state_d;
  logic go, fin;
  logic req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rd_buf_q, rd_buf_d;
  logic [3:0] sel_q, sel_d;
  always_comb begin
    go = state_q == IDLE && start;
    fin = state_q == BUSY && dbus_ack;
    state_d = go ? BUSY : fin ? DONE : (state_q == DONE && release_stage) ? IDLE : state_q;
    req_d = go ? 1'b1 : fin ? 1'b0 : req_q;
    we_d = go ? we : we_q;
    addr_d = go ? addr : addr_q;
    sel_d = go ? sel : sel_q;
    wdata_d = go ? wdata : wdata_q;
    rd_buf_d = fin ? dbus_rdata : rd_buf_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= ZERO_WORD;
      sel_q <= 4'b0000;
      wdata_q <= ZERO_WORD;
      rd_buf_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      sel_q <= sel_d;
      wdata_q <= wdata_d;
      rd_buf_q <= rd_buf_d;
    end
  end
  assign state = state_q;
  assign dbus_req = req_q;
  assign dbus_we = we_q;
  assign dbus_addr = addr_q;
  assign dbus_sel = sel_q;
  assign dbus_wdata = wdata_q;
  assign rd_buf = rd_buf_q;
endmodule

// File: rtl/mem_dbus_stage.sv
// mem_dbus_stage: OpenMIPS memory stage running loads/stores over a req/ack data bus
module mem_dbus_stage
  import mem_dbus_stage_pkg::*;
#(
  parameter int BIG_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic        mem_misalign,
  output logic        stallreq,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack
);
  dbus_state_e state;
  logic load, mem_op, mis, start, done_ld, unused_stall;
  logic [1:0] a, b_lane, h_lane;
  logic [3:0] sel;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [31:0] wdata, rd_buf, ld_data;
  assign unused_stall = ^{stall[5], stall[3:0]};
  always_comb begin
    a = ex_mem_addr[1:0];
    load = is_load(ex_aluop);
    mem_op = load || is_store(ex_aluop);
    mis = (is_half(ex_aluop) && a[0]) || (is_word(ex_aluop) && a != 2'b00);
    start = mem_op && !mis;
    b_lane = BIG_ENDIAN != 0 ? 2'd3 - a : a;
    h_lane = {(BIG_ENDIAN != 0) ^ a[1], 1'b0};
    sel = is_byte(ex_aluop) ? 4'b0001 << b_lane : is_half(ex_aluop) ? 4'b0011 << h_lane : 4'b1111;
    wdata = is_byte(ex_aluop) ? {4{ex_reg2[7:0]}} : is_half(ex_aluop) ? {2{ex_reg2[15:0]}} : ex_reg2;
    byte_v = 8'(rd_buf >> {b_lane, 3'b000});
    half_v = 16'(rd_buf >> {h_lane, 3'b000});
    ld_data = ex_aluop == EXE_LB_OP ? {{24{byte_v[7]}}, byte_v} :
              ex_aluop == EXE_LBU_OP ? {24'h000000, byte_v} :
              ex_aluop == EXE_LH_OP ? {{16{half_v[15]}}, half_v} :
              ex_aluop == EXE_LHU_OP ? {16'h0000, half_v} : rd_buf;
    done_ld = start && load && state == DONE;
    stallreq = rst && (state == BUSY || (state == IDLE && start));
    mem_wd = rst ? ex_wd : NOP_REG_ADDR;
    mem_wreg = rst && (mem_op ? done_ld && ex_wreg : ex_wreg);
    mem_wdata = !rst ? ZERO_WORD : done_ld ? ld_data : ex_wdata;
    mem_hi = rst ? ex_hi : ZERO_WORD;
    mem_lo = rst ? ex_lo : ZERO_WORD;
    mem_whilo = rst && !mem_op && ex_whilo;
    mem_misalign = rst && mem_op && mis;
  end
  dbus_if u_dbus_if (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .release_stage (stall[4] == NO_STOP),
    .we            (is_store(ex_aluop)),
    .addr          ({ex_mem_addr[31:2], 2'b00}),
    .sel           (sel),
    .wdata         (wdata),
    .dbus_rdata    (dbus_rdata),
    .dbus_ack      (dbus_ack),
    .state         (state),
    .dbus_req      (dbus_req),
    .dbus_we       (dbus_we),
    .dbus_addr     (dbus_addr),
    .dbus_sel      (dbus_sel),
    .dbus_wdata    (dbus_wdata),
    .rd_buf        (rd_buf)
  );
endmodule

// File: tb/tb_mem_dbus_stage.sv
// tb_mem_dbus_stage: vector table, directed bus sequences and randomized accesses against a reference model
module tb_mem_dbus_stage;
  import mem_dbus_stage_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [5:0] stall = 6'b0;
  logic [4:0] ex_wd = 5'd0;
  logic ex_wreg = 1'b0, ex_whilo = 1'b0;
  logic [31:0] ex_wdata = 32'h0, ex_hi = 32'h0, ex_lo = 32'h0, ex_mem_addr = 32'h0, ex_reg2 = 32'h0;
  logic [7:0] ex_aluop = EXE_NOP_OP;
  logic [4:0] mem_wd;
  logic mem_wreg, mem_whilo, mem_misalign, stallreq, dbus_req, dbus_we;
  logic [31:0] mem_wdata, mem_hi, mem_lo, dbus_addr, dbus_wdata;
  logic [3:0] dbus_sel;
  logic [31:0] dbus_rdata = 32'h0;
  logic dbus_ack = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  mem_dbus_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_whilo(mem_whilo), .mem_misalign(mem_misalign), .stallreq(stallreq),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_sel(dbus_sel),
    .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
  );
  typedef struct {
    logic [7:0] op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0] wd;
    logic wreg;
    logic whilo;
    logic [31:0] e_wdata;
    logic e_wreg;
    logic e_whilo;
    logic e_mis;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic logic is_ld(input logic [7:0] op);
    return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_LW_OP;
  endfunction
  function automatic logic is_b(input logic [7:0] op);
    return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP;
  endfunction
  function automatic logic is_h(input logic [7:0] op);
    return op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP;
  endfunction
  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * (3 - int'(a)))) & 32'hFF;
    h = a[1] ? d & 32'hFFFF : d >> 16;
    if (op == EXE_LB_OP) return b >= 128 ? b + 32'hFFFF_FF00 : b;
    if (op == EXE_LBU_OP) return b;
    if (op == EXE_LH_OP) return h >= 32768 ? h + 32'hFFFF_0000 : h;
    if (op == EXE_LHU_OP) return h;
    return d;
  endfunction
  function automatic logic [3:0] ref_sel(input logic [7:0] op, input logic [1:0] a);
    if (is_b(op)) return 4'b1000 >> a;
    if (is_h(op)) return a[1] ? 4'b0011 : 4'b1100;
    return 4'b1111;
  endfunction
  function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [31:0] r);
    if (is_b(op)) return r[7:0] * 32'h0101_0101;
    if (is_h(op)) return r[15:0] * 32'h0001_0001;
    return r;
  endfunction
  task automatic mem_access(input string tag, input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] reg2, input logic [31:0] rdata, input int ack_wait, input int hold);
    logic ld, st;
    logic [31:0] exp_ld;
    int sc;
    ld = is_ld(op);
    st = !ld;
    exp_ld = ref_load(op, addr[1:0], rdata);
    sc = 0;
    @(posedge clk); #1;
    ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2; ex_wd = 5'd9; ex_wreg = 1'b1;
    ex_whilo = 1'b1; ex_wdata = 32'h0BAD_F00D; stall = 6'b0; dbus_ack = 1'b0;
    @(negedge clk);
    sc += int'(stallreq);
    chk({tag, ":idle_stallreq"}, stallreq, 1);
    chk({tag, ":idle_req"}, dbus_req, 0);
    chk({tag, ":idle_wreg"}, mem_wreg, 0);
    chk({tag, ":idle_whilo"}, mem_whilo, 0);
    for (int i = 0; i <= ack_wait; i++) begin
      @(posedge clk); #1;
      dbus_ack = (i == ack_wait);
      dbus_rdata = (i == ack_wait) ? rdata : $urandom;
      @(negedge clk);
      sc += int'(stallreq);
      chk({tag, ":busy_req"}, dbus_req, 1);
      chk({tag, ":busy_addr"}, dbus_addr, addr & 32'hFFFF_FFFC);
      chk({tag, ":busy_sel"}, dbus_sel, ref_sel(op, addr[1:0]));
      chk({tag, ":busy_we"}, dbus_we, st);
      if (st) chk({tag, ":busy_wdata"}, dbus_wdata, ref_wdata(op, reg2));
      chk({tag, ":busy_wreg"}, mem_wreg, 0);
    end
    @(posedge clk); #1;
    dbus_ack = 1'b0; dbus_rdata = $urandom; stall[4] = (hold > 0) ? STOP : NO_STOP;
    @(negedge clk);
    sc += int'(stallreq);
    chk({tag, ":done_stallreq"}, stallreq, 0);
    chk({tag, ":done_req"}, dbus_req, 0);
    chk({tag, ":done_wreg"}, mem_wreg, ld);
    if (ld) chk({tag, ":done_wdata"}, mem_wdata, exp_ld);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      stall[4] = (h < hold - 1) ? STOP : NO_STOP;
      dbus_ack = 1'b1; dbus_rdata = ~rdata;
      @(negedge clk);
      sc += int'(stallreq);
      chk({tag, ":hold_stallreq"}, stallreq, 0);
      chk({tag, ":hold_req"}, dbus_req, 0);
      chk({tag, ":hold_wreg"}, mem_wreg, ld);
      if (ld) chk({tag, ":hold_wdata"}, mem_wdata, exp_ld);
    end
    chk({tag, ":stall_cycles"}, sc, ack_wait + 2);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tbl [9];
    logic [7:0] mops [8];
    logic [7:0] pops [3];
    logic [7:0] op;
    logic [31:0] addr, wd32;
    logic wr, wh;
    logic [4:0] wd5;
    mops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    pops = '{EXE_ADDU_OP, EXE_OR_OP, EXE_NOP_OP};
    tbl[0] = '{EXE_ADDU_OP, 32'h0000_0000, 32'h0000_0005, 5'd3, 1'b1, 1'b0, 32'h0000_0005, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{EXE_OR_OP, 32'h0000_0000, 32'hA5A5_0F0F, 5'd7, 1'b0, 1'b1, 32'hA5A5_0F0F, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{EXE_NOP_OP, 32'h0000_1234, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{EXE_LW_OP, 32'h0000_0102, 32'h0000_0011, 5'd4, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{EXE_LW_OP, 32'h0000_0103, 32'h0000_0011, 5'd4, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{EXE_LH_OP, 32'h0000_0101, 32'h0000_0011, 5'd4, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{EXE_LHU_OP, 32'h0000_0103, 32'h0000_0011, 5'd4, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{EXE_SH_OP, 32'h0000_0105, 32'h0000_0011, 5'd4, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{EXE_SW_OP, 32'h0000_0101, 32'h0000_0011, 5'd4, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1};
    #1;
    ex_aluop = EXE_LH_OP; ex_mem_addr = 32'h0000_0101; ex_wd = 5'd5; ex_wreg = 1'b1;
    ex_wdata = 32'h1234_5678; ex_hi = 32'h1111_1111; ex_lo = 32'h2222_2222; ex_whilo = 1'b1;
    @(negedge clk);
    chk("rst_wd", mem_wd, NOP_REG_ADDR);
    chk("rst_wreg", mem_wreg, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_hi", mem_hi, 0);
    chk("rst_lo", mem_lo, 0);
    chk("rst_whilo", mem_whilo, 0);
    chk("rst_misalign", mem_misalign, 0);
    chk("rst_stallreq", stallreq, 0);
    chk("rst_req", dbus_req, 0);
    chk("rst_sel", dbus_sel, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      ex_aluop = tbl[i].op; ex_mem_addr = tbl[i].addr; ex_wdata = tbl[i].wdata; ex_wd = tbl[i].wd;
      ex_wreg = tbl[i].wreg; ex_whilo = tbl[i].whilo; ex_hi = 32'hC0DE_0000 | i; ex_lo = ~ex_hi;
      ex_reg2 = 32'h5555_AAAA; stall = 6'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d_wreg", i), mem_wreg, tbl[i].e_wreg);
      chk($sformatf("tbl%0d_misalign", i), mem_misalign, tbl[i].e_mis);
      chk($sformatf("tbl%0d_whilo", i), mem_whilo, tbl[i].e_whilo);
      chk($sformatf("tbl%0d_stallreq", i), stallreq, 0);
      chk($sformatf("tbl%0d_req", i), dbus_req, 0);
      chk($sformatf("tbl%0d_hi", i), mem_hi, 32'hC0DE_0000 | i);
      chk($sformatf("tbl%0d_lo", i), mem_lo, ~(32'hC0DE_0000 | i));
      if (!tbl[i].e_mis) begin
        chk($sformatf("tbl%0d_wdata", i), mem_wdata, tbl[i].e_wdata);
        chk($sformatf("tbl%0d_wd", i), mem_wd, tbl[i].wd);
      end
    end
    mem_access("lw100", EXE_LW_OP, 32'h0000_0100, 32'h0, 32'h1234_5678, 1, 0);
    mem_access("lb101", EXE_LB_OP, 32'h0000_0101, 32'h0, 32'h12F4_5678, 0, 0);
    mem_access("lbu101", EXE_LBU_OP, 32'h0000_0101, 32'h0, 32'h12F4_5678, 0, 0);
    mem_access("sh102", EXE_SH_OP, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 1, 0);
    mem_access("lw_hold", EXE_LW_OP, 32'h0000_0200, 32'h0, 32'hCAFE_BABE, 0, 2);
    mem_access("lh_after", EXE_LH_OP, 32'h0000_0302, 32'h0, 32'h0000_8001, 2, 0);
    @(posedge clk); #1;
    ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h0000_0400; stall = 6'b0; dbus_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy_pre_req", dbus_req, 1);
    #1 rst = 1'b0;
    #1;
    chk("rstbusy_req", dbus_req, 0);
    chk("rstbusy_stallreq", stallreq, 0);
    chk("rstbusy_wreg", mem_wreg, 0);
    @(posedge clk); #1;
    ex_aluop = EXE_NOP_OP; rst = 1'b1;
    mem_access("lw_post_rst", EXE_LW_OP, 32'h0000_0400, 32'h0, 32'h8765_4321, 1, 0);
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        op = pops[$urandom_range(0, 2)];
        wd32 = $urandom; wd5 = 5'($urandom); wr = 1'($urandom); wh = 1'($urandom);
        @(posedge clk); #1;
        ex_aluop = op; ex_wdata = wd32; ex_wd = wd5; ex_wreg = wr; ex_whilo = wh;
        ex_mem_addr = $urandom; stall = 6'b0; dbus_ack = 1'b0;
        @(negedge clk);
        chk("rnd_pass_wdata", mem_wdata, wd32);
        chk("rnd_pass_wd", mem_wd, wd5);
        chk("rnd_pass_wreg", mem_wreg, wr);
        chk("rnd_pass_whilo", mem_whilo, wh);
        chk("rnd_pass_stallreq", stallreq, 0);
      end else begin
        op = mops[$urandom_range(0, 7)];
        addr = $urandom & 32'hFFFF_FFFC;
        if (is_b(op)) addr = addr | $urandom_range(0, 3);
        if (is_h(op)) addr = addr | ($urandom_range(0, 1) << 1);
        mem_access($sformatf("rnd%0d_op%h", r, op), op, addr, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
